fpu_div_iter: RTL
=================

// Module: fpu_div_iter
// PURPOSE
//  Iterative radix-2 restoring FP32 divider, consumer of the FPU classify/decode stage.
//  Takes two decoded operands (sign, unbiased exp, 24-bit sig with hidden 1, 6-bit class)
//  and produces an unrounded quotient (26 sig bits + sticky) or a resolved special result.
//  Feeds the FPU round/pack stage. One quotient bit per cycle; single operation in flight.
// PARAMETERS
//  QBITS  26  quotient bits generated: 24 sig + guard + round. Legal range 25..28.
// PORTS
//  clk_i         in   1      clock, all state on rising edge
//  resetn_i      in   1      asynchronous, active-low reset
//  start_i       in   1      launch divide; sampled only in IDLE, ignored otherwise
//  aSign_i       in   1      dividend sign
//  aExp_i        in   10     dividend unbiased exponent, signed
//  aSig_i        in   24     dividend significand, bit 23 = 1 for non-zero
//  aClass_i      in   6      {qNaN,sNaN,inf,norm,sub,zero}, one-hot
//  bSign_i/bExp_i/bSig_i/bClass_i  in  1/10/24/6  divisor, same encoding as a
//  busy_o        out  1      high from the cycle after start through DONE
//  done_o        out  1      one-cycle pulse; result outputs valid while high and held after
//  qSign_o       out  1      aSign ^ bSign, also for specials other than NaN (NaN: 0)
//  qExp_o        out  10     signed quotient exponent, unrounded
//  qSig_o        out  QBITS  quotient, MSB = 1 for a non-special result
//  sticky_o      out  1      final remainder != 0
//  special_o     out  1      result is special; specialRes_o is authoritative
//  specialRes_o  out  32     packed FP32 special result
//  flags_o       out  2      {NV, DZ}
// BEHAVIOUR
//  Reset: state IDLE; every output 0. Reset mid-operation aborts; no done_o.
//  FSM: IDLE -start_i-> PREP -> (special ? DONE : ITER) ; ITER x QBITS -> DONE -> IDLE.
//  PREP: sign/special decode; if aSig < bSig then rem = {aSig,1'b0}, adj = 1,
//   else rem = {1'b0,aSig}, adj = 0 (rem 25 bits). qExp = aExp - bExp - adj (10-bit signed, no overflow).
//  ITER k: if rem >= bSig then rem -= bSig, q bit = 1 else q bit = 0; rem <<= 1; MSB first.
//  Latency start->done_o: special 2 cycles; normal QBITS+2 cycles. A new start_i is
//   accepted in the cycle after DONE (IDLE); start_i during DONE is ignored.
//  Specials (priority order): any NaN -> 0x7FC00000, NV if either sNaN;
//   0/0 or inf/inf -> 0x7FC00000, NV; inf/x -> signed inf; x/0 (x finite) -> signed inf, DZ;
//   0/x or x/inf -> signed zero. Special: qSig_o = 0, sticky_o = 0, qExp_o = 0.
//  Non-special: special_o = 0, specialRes_o = 0, flags_o = 0.
//  Outputs registered; change only on the DONE transition.
// CONFIGURATION
//  FPU_DIV_EARLY_OUT_EN defined: in PREP, bSig == 24'h800000 (divisor a power of two) skips
//   ITER: qSig_o = {aSig, 0...}, sticky_o = 0, qExp_o = aExp - bExp; done_o 2 cycles after start.
//  Undefined: such divisors run the full QBITS iterations; results identical, latency QBITS+2.
// STRUCTURE
//  fpu_pkg: CLASS_ZERO..CLASS_QNAN bit indices, CANON_NAN = 32'h7FC00000,
//   FLAG_NV/FLAG_DZ positions, FSM state enum.
//  Sub-module fpu_div_special: combinational special-case resolver (classes+signs ->
//   special, result, flags); the iterative datapath and FSM stay in fpu_div_iter.
// TESTING
//  6.0/3.0 (sig 0xC00000/0xC00000, exp 2/1) -> qSig 26'h2000000, qExp 1, sticky 0, done at +28.
//  1.0/3.0 -> adj=1, qExp -2, qSig 26'h2AAAAAA, sticky 1.
//  5.0/0.0 -> special, 0x7F800000, flags 2'b01, done at +2; -5.0/+0 -> 0xFF800000.
//  0/0 -> 0x7FC00000, NV; sNaN(0x7F800001)/1.0 -> 0x7FC00000, NV; inf/inf -> NaN, NV.
//  Subnormal dividend (exp -130, sig 0x800000)/2.0 -> qExp -131, qSig MSB 1, no special.
//  resetn_i low at ITER cycle 10 -> outputs 0, IDLE; next start completes normally;
//   start_i held during busy -> ignored; back-to-back ops with start in cycle after done.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU divide path: operand class bit positions,
// canonical NaN, exception flag positions and the divider FSM state type.
package fpu_pkg;

    // Bit positions inside the one-hot 6-bit class {qNaN,sNaN,inf,norm,sub,zero}
    localparam int CLASS_ZERO = 0;
    localparam int CLASS_SUB  = 1;
    localparam int CLASS_NORM = 2;
    localparam int CLASS_INF  = 3;
    localparam int CLASS_SNAN = 4;
    localparam int CLASS_QNAN = 5;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    // Flag vector is {NV, DZ}
    localparam int FLAG_DZ = 0;
    localparam int FLAG_NV = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_ITER = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/fpu_div_special.sv
// Combinational special-case resolver for FP32 division. Looks only at the
// operand classes and signs and decides whether the quotient is a special
// value (NaN, signed infinity, signed zero), which value, and which flags.
module fpu_div_special
    import fpu_pkg::*;
(
    input  logic        a_sign,
    input  logic [5:0]  a_class,
    input  logic        b_sign,
    input  logic [5:0]  b_class,
    output logic        special,
    output logic [31:0] result,
    output logic [1:0]  flags,
    output logic        sign
);

    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_fin, b_fin, q_sign;

    assign a_nan  = a_class[CLASS_QNAN] | a_class[CLASS_SNAN];
    assign b_nan  = b_class[CLASS_QNAN] | b_class[CLASS_SNAN];
    assign a_inf  = a_class[CLASS_INF];
    assign b_inf  = b_class[CLASS_INF];
    assign a_zero = a_class[CLASS_ZERO];
    assign b_zero = b_class[CLASS_ZERO];
    assign a_fin  = a_class[CLASS_ZERO] | a_class[CLASS_SUB] | a_class[CLASS_NORM];
    assign b_fin  = b_class[CLASS_ZERO] | b_class[CLASS_SUB] | b_class[CLASS_NORM];
    assign q_sign = a_sign ^ b_sign;

    // Priority-ordered special resolution; NaN results carry a positive sign
    always_comb begin
        special = 1'b0;
        result  = 32'h0;
        flags   = 2'b00;
        sign    = q_sign;
        if (a_nan || b_nan) begin
            special        = 1'b1;
            result         = CANON_NAN;
            sign           = 1'b0;
            flags[FLAG_NV] = a_class[CLASS_SNAN] | b_class[CLASS_SNAN];
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            special        = 1'b1;
            result         = CANON_NAN;
            sign           = 1'b0;
            flags[FLAG_NV] = 1'b1;
        end else if (a_inf) begin
            special = 1'b1;
            result  = {q_sign, 8'hFF, 23'h0};
        end else if (b_zero && a_fin) begin
            special        = 1'b1;
            result         = {q_sign, 8'hFF, 23'h0};
            flags[FLAG_DZ] = 1'b1;
        end else if ((a_zero && b_fin) || b_inf) begin
            special = 1'b1;
            result  = {q_sign, 31'h0};
        end
    end

endmodule

// File: rtl/fpu_div_iter.sv
// Iterative radix-2 restoring FP32 divider producing an unrounded quotient
// (QBITS significand bits + sticky) or a resolved special result.
// Optional build macro: FPU_DIV_EARLY_OUT_EN -- a divisor significand of
// exactly 1.0 (24'h800000) bypasses the iteration and finishes from PREP.
module fpu_div_iter
    import fpu_pkg::*;
#(
    parameter int QBITS = 26
)
(
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             start_i,
    input  logic             aSign_i,
    input  logic [9:0]       aExp_i,
    input  logic [23:0]      aSig_i,
    input  logic [5:0]       aClass_i,
    input  logic             bSign_i,
    input  logic [9:0]       bExp_i,
    input  logic [23:0]      bSig_i,
    input  logic [5:0]       bClass_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             qSign_o,
    output logic [9:0]       qExp_o,
    output logic [QBITS-1:0] qSig_o,
    output logic             sticky_o,
    output logic             special_o,
    output logic [31:0]      specialRes_o,
    output logic [1:0]       flags_o
);

    localparam int CW = $clog2(QBITS);

    div_state_t       state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [24:0]      rem_reg;
    logic [QBITS-1:0] quo_reg;
    logic [9:0]       exp_reg;

    // Operands captured at launch so the inputs may change during the divide
    logic             a_sign_reg, b_sign_reg;
    logic [9:0]       a_exp_reg, b_exp_reg;
    logic [23:0]      a_sig_reg, b_sig_reg;
    logic [5:0]       a_class_reg, b_class_reg;

    logic             spc_special, spc_sign;
    logic [31:0]      spc_result;
    logic [1:0]       spc_flags;

    logic             rem_ge, a_lt_b;
    logic [24:0]      rem_sub, rem_next;
    logic [QBITS-1:0] quo_next;
    logic [9:0]       exp_prep;

    fpu_div_special u_special (
        .a_sign  (a_sign_reg),
        .a_class (a_class_reg),
        .b_sign  (b_sign_reg),
        .b_class (b_class_reg),
        .special (spc_special),
        .result  (spc_result),
        .flags   (spc_flags),
        .sign    (spc_sign)
    );

    // One restoring step plus the PREP alignment decision
    always_comb begin
        rem_ge   = rem_reg >= {1'b0, b_sig_reg};
        rem_sub  = rem_ge ? (rem_reg - {1'b0, b_sig_reg}) : rem_reg;
        rem_next = rem_sub << 1;
        quo_next = {quo_reg[QBITS-2:0], rem_ge};
        a_lt_b   = a_sig_reg < b_sig_reg;
        exp_prep = a_exp_reg - b_exp_reg - {9'd0, a_lt_b};
    end

    // Control FSM, datapath registers and registered result outputs
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            rem_reg      <= '0;
            quo_reg      <= '0;
            exp_reg      <= '0;
            a_sign_reg   <= 1'b0;
            b_sign_reg   <= 1'b0;
            a_exp_reg    <= '0;
            b_exp_reg    <= '0;
            a_sig_reg    <= '0;
            b_sig_reg    <= '0;
            a_class_reg  <= '0;
            b_class_reg  <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            qSign_o      <= 1'b0;
            qExp_o       <= '0;
            qSig_o       <= '0;
            sticky_o     <= 1'b0;
            special_o    <= 1'b0;
            specialRes_o <= '0;
            flags_o      <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    if (start_i) begin
                        a_sign_reg  <= aSign_i;
                        a_exp_reg   <= aExp_i;
                        a_sig_reg   <= aSig_i;
                        a_class_reg <= aClass_i;
                        b_sign_reg  <= bSign_i;
                        b_exp_reg   <= bExp_i;
                        b_sig_reg   <= bSig_i;
                        b_class_reg <= bClass_i;
                        busy_o      <= 1'b1;
                        state_reg   <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    if (spc_special) begin
                        qSign_o      <= spc_sign;
                        qExp_o       <= '0;
                        qSig_o       <= '0;
                        sticky_o     <= 1'b0;
                        special_o    <= 1'b1;
                        specialRes_o <= spc_result;
                        flags_o      <= spc_flags;
                        done_o       <= 1'b1;
                        state_reg    <= ST_DONE;
`ifdef FPU_DIV_EARLY_OUT_EN
                    end else if (b_sig_reg == 24'h800000) begin
                        qSign_o      <= spc_sign;
                        qExp_o       <= a_exp_reg - b_exp_reg;
                        qSig_o       <= {a_sig_reg, {(QBITS-24){1'b0}}};
                        sticky_o     <= 1'b0;
                        special_o    <= 1'b0;
                        specialRes_o <= '0;
                        flags_o      <= '0;
                        done_o       <= 1'b1;
                        state_reg    <= ST_DONE;
`endif
                    end else begin
                        // Pre-shift the dividend when it is smaller so the first quotient bit is 1
                        rem_reg   <= a_lt_b ? {a_sig_reg, 1'b0} : {1'b0, a_sig_reg};
                        exp_reg   <= exp_prep;
                        quo_reg   <= '0;
                        cnt_reg   <= '0;
                        state_reg <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    rem_reg <= rem_next;
                    quo_reg <= quo_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CW'(QBITS - 1)) begin
                        qSign_o      <= spc_sign;
                        qExp_o       <= exp_reg;
                        qSig_o       <= quo_next;
                        sticky_o     <= (rem_sub != '0);
                        special_o    <= 1'b0;
                        specialRes_o <= '0;
                        flags_o      <= '0;
                        done_o       <= 1'b1;
                        state_reg    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_o    <= 1'b0;
                    busy_o    <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
